// File: rtl/posit_stream_checker.sv
// posit_stream_checker
// On-chip scoreboard for posit arithmetic pipelines. Each expected result is
// queued together with a timestamp when its operands are issued to the DUT.
// Each DUT result pops one entry. The block then compares the two words,
// measures the sample latency and accumulates error statistics.
//
// Handshake: in_valid and dut_done are single-cycle strobes with no
// backpressure. Nothing is ever stalled. full and empty are status outputs
// only:
//   - a push that finds no room is dropped and sets overflow;
//   - a pop that finds nothing queued is ignored and sets underflow.
//
// Ports:
//   aclk, aresetn         clock (rising edge), asynchronous active-low reset
//   clear                 synchronous clear of FIFO, counters, flags, captures
//   in_valid, exp_in      push golden result (stamped with the current ts)
//   dut_done, dut_out     pop the oldest entry and compare it with dut_out
//   empty, full           FIFO status
//   cmp_valid             one-cycle pulse; cmp_diff/cmp_mismatch just updated
//   cmp_diff, cmp_mismatch
//                         |exp - act| and pass/fail of the last compare
//   checked_cnt, err_cnt, lat_err_cnt
//                         saturating statistics counters
//   max_diff, max_lat     running maxima
//   first_err_*           capture of the first mismatch (sticky)
//   overflow, underflow   sticky FIFO misuse flags
module posit_stream_checker #(
  parameter int N         = 8,
  parameter int LATENCY   = 6,
  parameter int DEPTH     = 16,
  parameter int TOL       = 0,
  parameter int CHECK_LAT = 1,
  parameter int CNT_W     = 32,
  parameter int TS_W      = 8
) (
  input  logic             aclk,
  input  logic             aresetn,
  input  logic             clear,
  input  logic             in_valid,
  input  logic [N-1:0]     exp_in,
  input  logic             dut_done,
  input  logic [N-1:0]     dut_out,
  output logic             empty,
  output logic             full,
  output logic             cmp_valid,
  output logic [N-1:0]     cmp_diff,
  output logic             cmp_mismatch,
  output logic [CNT_W-1:0] checked_cnt,
  output logic [CNT_W-1:0] err_cnt,
  output logic [CNT_W-1:0] lat_err_cnt,
  output logic [N-1:0]     max_diff,
  output logic [TS_W-1:0]  max_lat,
  output logic             first_err_valid,
  output logic [N-1:0]     first_err_exp,
  output logic [N-1:0]     first_err_act,
  output logic [CNT_W-1:0] first_err_idx,
  output logic             overflow,
  output logic             underflow
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [N-1:0] NAR   = {1'b1, {(N-1){1'b0}}};
  localparam logic [N:0]   TOL_W = (N+1)'(TOL);

  logic [TS_W-1:0]   ts;
  logic [N+TS_W-1:0] mem [DEPTH];
  // One extra pointer bit distinguishes full from empty.
  logic [AW:0]       wr_ptr;
  logic [AW:0]       rd_ptr;
  logic [AW:0]       occ;

  logic              push;
  logic              pop;
  logic [N+TS_W-1:0] rd_entry;
  logic [N-1:0]      e_exp;
  logic [TS_W-1:0]   e_ts;
  logic [N-1:0]      diff;
  logic [TS_W-1:0]   lat;
  logic              is_nar;
  logic              mismatch;
  logic              lat_bad;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  assign occ   = wr_ptr - rd_ptr;
  assign empty = (wr_ptr == rd_ptr);
  assign full  = (occ == (AW+1)'(DEPTH));

  // There is no bypass path, so a pop needs an entry that was already stored.
  // A push while full still lands if the same edge pops, keeping occupancy.
  assign pop  = dut_done && !empty;
  assign push = in_valid && (!full || pop);

  assign rd_entry = mem[rd_ptr[AW-1:0]];
  assign e_exp    = rd_entry[N+TS_W-1:TS_W];
  assign e_ts     = rd_entry[TS_W-1:0];

  assign diff = (e_exp >= dut_out) ? (e_exp - dut_out) : (dut_out - e_exp);
  // Latency is a modular difference, so it stays correct across ts wrap.
  assign lat  = ts - e_ts;

  // NaR only ever matches NaR exactly, so the tolerance window is bypassed.
  assign is_nar   = (e_exp == NAR) || (dut_out == NAR);
  assign mismatch = is_nar ? (e_exp != dut_out) : ({1'b0, diff} > TOL_W);
  assign lat_bad  = (CHECK_LAT != 0) && (lat != TS_W'(LATENCY));

  // Free-running timestamp; clear deliberately leaves it alone.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) ts <= '0;
    else          ts <= ts + TS_W'(1);
  end

  always_ff @(posedge aclk) begin
    if (push && !clear) mem[wr_ptr[AW-1:0]] <= {exp_in, ts};
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      wr_ptr          <= '0;
      rd_ptr          <= '0;
      cmp_valid       <= 1'b0;
      cmp_diff        <= '0;
      cmp_mismatch    <= 1'b0;
      checked_cnt     <= '0;
      err_cnt         <= '0;
      lat_err_cnt     <= '0;
      max_diff        <= '0;
      max_lat         <= '0;
      first_err_valid <= 1'b0;
      first_err_exp   <= '0;
      first_err_act   <= '0;
      first_err_idx   <= '0;
      overflow        <= 1'b0;
      underflow       <= 1'b0;
    end else if (clear) begin
      wr_ptr          <= '0;
      rd_ptr          <= '0;
      cmp_valid       <= 1'b0;
      cmp_diff        <= '0;
      cmp_mismatch    <= 1'b0;
      checked_cnt     <= '0;
      err_cnt         <= '0;
      lat_err_cnt     <= '0;
      max_diff        <= '0;
      max_lat         <= '0;
      first_err_valid <= 1'b0;
      first_err_exp   <= '0;
      first_err_act   <= '0;
      first_err_idx   <= '0;
      overflow        <= 1'b0;
      underflow       <= 1'b0;
    end else begin
      cmp_valid <= pop;
      if (push) wr_ptr <= wr_ptr + (AW+1)'(1);
      if (in_valid && !push) overflow <= 1'b1;
      if (dut_done && empty) underflow <= 1'b1;
      if (pop) begin
        rd_ptr       <= rd_ptr + (AW+1)'(1);
        cmp_diff     <= diff;
        cmp_mismatch <= mismatch;
        checked_cnt  <= sat_inc(checked_cnt);
        if (mismatch) err_cnt <= sat_inc(err_cnt);
        if (lat_bad) lat_err_cnt <= sat_inc(lat_err_cnt);
        if (diff > max_diff) max_diff <= diff;
        if (lat > max_lat) max_lat <= lat;
        if (mismatch && !first_err_valid) begin
          first_err_valid <= 1'b1;
          first_err_exp   <= e_exp;
          first_err_act   <= dut_out;
          first_err_idx   <= checked_cnt;
        end
      end
    end
  end

endmodule
